// File: rtl/spike_event_encoder_if.sv
// Event port between the spike encoder and its consumer.
// Latency: none, this file only bundles the valid/ready signals.
// Backpressure: the consumer holds ev_ready low and the producer keeps the head event stable.
interface spike_event_encoder_if #(
    parameter int CH_W = 1,
    parameter int TS_W = 8
);
    logic            ev_valid;
    logic            ev_ready;
    logic [CH_W-1:0] ev_chan;
    logic [TS_W-1:0] ev_ts;

    modport master (output ev_valid, output ev_chan, output ev_ts, input ev_ready);
    modport slave  (input ev_valid, input ev_chan, input ev_ts, output ev_ready);
endinterface

// File: rtl/spike_event_encoder.sv
// Captures spike pulses, stamps each with the timestep count, and queues them as events.
// Latency: a spike in cycle t is pending at edge t, is pushed at edge t+1, and is visible in cycle t+2.
// Backpressure: a full FIFO holds pending slots; a repeat spike on a held channel is dropped and counted.
module spike_event_encoder #(
    parameter int N_CH  = 2,
    parameter int CH_W  = 1,
    parameter int TS_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          spike_in,
    input  logic                     tick,
    spike_event_encoder_if.master    ev,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [TS_W-1:0]  ts_cnt;
    logic [N_CH-1:0]  pending;
    logic [TS_W-1:0]  pend_ts   [N_CH];
    logic [CH_W-1:0]  fifo_chan [DEPTH];
    logic [TS_W-1:0]  fifo_ts   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             head_vld;
    logic             full;
    logic             pop;
    logic             push;
    logic             sel_vld;
    logic [CH_W-1:0]  sel_idx;
    logic [N_CH-1:0]  drained;
    logic [N_CH-1:0]  drop_vec;
    logic [CH_W:0]    n_drop;
    logic [8:0]       drop_sum;

    assign head_vld = (fifo_level != '0);
    assign full     = (fifo_level == LVL_W'(DEPTH));
    assign pop      = head_vld && ev.ev_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push     = sel_vld && (!full || pop);

    // Fixed-priority pick of the lowest-index pending channel.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_vld = 1'b1;
                sel_idx = CH_W'(i);
            end
        end
    end

    // Per-channel drain and drop decisions, plus how many spikes are lost this edge.
    always_comb begin
        drained = '0;
        drop_vec = '0;
        n_drop = '0;
        for (int i = 0; i < N_CH; i++) begin
            drained[i]  = push && (sel_idx == CH_W'(i));
            drop_vec[i] = spike_in[i] && pending[i] && !drained[i];
            n_drop      = n_drop + {{CH_W{1'b0}}, drop_vec[i]};
        end
        drop_sum = {1'b0, drop_cnt} + 9'(n_drop);
    end

    // Timestep counter and pending slots; a spike sees the pre-increment count.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt  <= '0;
            pending <= '0;
            for (int i = 0; i < N_CH; i++) pend_ts[i] <= '0;
        end else begin
            if (tick) ts_cnt <= ts_cnt + TS_W'(1);
            for (int i = 0; i < N_CH; i++) begin
                if (spike_in[i] && (!pending[i] || drained[i])) begin
                    pending[i] <= 1'b1;
                    pend_ts[i] <= ts_cnt;
                end else if (drained[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (|drop_vec) begin
            overflow <= 1'b1;
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // FIFO storage; contents need no reset because the outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_chan[wr_ptr] <= sel_idx;
            fifo_ts[wr_ptr]   <= pend_ts[sel_idx];
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      fifo_level <= fifo_level + LVL_W'(1);
            else if (pop && !push) fifo_level <= fifo_level - LVL_W'(1);
        end
    end

    assign ev.ev_valid = head_vld;
    assign ev.ev_chan  = head_vld ? fifo_chan[rd_ptr] : '0;
    assign ev.ev_ts    = head_vld ? fifo_ts[rd_ptr]   : '0;
endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: a per-cycle vector table plus hand-written corner sequences.
// Each step drives inputs just after a rising edge and samples outputs 1 time unit after the edge.
// Expected values are hand-computed constants.
module tb_spike_event_encoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] spike_in;
    logic       tick;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    spike_event_encoder_if #(.CH_W(1), .TS_W(8)) ev_if ();

    spike_event_encoder #(.N_CH(2), .CH_W(1), .TS_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .spike_in   (spike_in),
        .tick       (tick),
        .ev         (ev_if),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    typedef struct {
        logic       rst;
        logic [1:0] spk;
        logic       tck;
        logic       rdy;
        logic       vld;
        logic       chan;
        logic [7:0] ts;
        logic [2:0] lvl;
        logic       ovf;
        logic [7:0] drop;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] s, input logic t, input logic rd);
        rst            = r;
        spike_in       = s;
        tick           = t;
        ev_if.ev_ready = rd;
    endtask

    task automatic add(input logic r, input logic [1:0] s, input logic t, input logic rd,
                       input logic v, input logic c, input logic [7:0] ts,
                       input logic [2:0] l, input logic o, input logic [7:0] d);
        vec_t x;
        x.rst = r; x.spk = s; x.tck = t; x.rdy = rd;
        x.vld = v; x.chan = c; x.ts = ts; x.lvl = l; x.ovf = o; x.drop = d;
        vq.push_back(x);
    endtask

    task automatic check_head(input string nm, input logic v, input logic c,
                              input logic [7:0] ts, input logic [2:0] l);
        chk({nm, " valid"}, 32'(ev_if.ev_valid), 32'(v));
        chk({nm, " chan"},  32'(ev_if.ev_chan),  32'(c));
        chk({nm, " ts"},    32'(ev_if.ev_ts),    32'(ts));
        chk({nm, " level"}, 32'(fifo_level),     32'(l));
    endtask

    logic exp_chan [6];
    logic [7:0] exp_ts [6];
    logic got_chan [6];
    logic [7:0] got_ts [6];

    initial begin
        drive(1'b1, 2'b00, 1'b0, 1'b1);

        // Reset and idle.
        for (int i = 0; i < 2; i++)  add(1, 2'b00, 0, 1,  0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 2'b00, 0, 1,  0, 0, 0, 0, 0, 0);
        // Single spike after 5 ticks: visible two cycles later for one cycle.
        for (int i = 0; i < 5; i++)  add(0, 2'b00, 1, 1,  0, 0, 0, 0, 0, 0);
        add(0, 2'b01, 0, 1,  0, 0, 8'd0, 0, 0, 0);
        add(0, 2'b00, 0, 1,  1, 0, 8'd5, 1, 0, 0);
        add(0, 2'b00, 0, 1,  0, 0, 8'd0, 0, 0, 0);
        add(0, 2'b00, 0, 1,  0, 0, 8'd0, 0, 0, 0);
        // Restart, then both channels spike with a tick at ts = 3.
        add(1, 2'b00, 0, 1,  0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)  add(0, 2'b00, 1, 1,  0, 0, 0, 0, 0, 0);
        add(0, 2'b11, 1, 1,  0, 0, 8'd0, 0, 0, 0);
        add(0, 2'b00, 0, 1,  1, 0, 8'd3, 1, 0, 0);
        add(0, 2'b00, 0, 1,  1, 1, 8'd3, 1, 0, 0);
        add(0, 2'b00, 0, 1,  0, 0, 8'd0, 0, 0, 0);
        // The counter now reads 4.
        add(0, 2'b01, 0, 1,  0, 0, 8'd0, 0, 0, 0);
        add(0, 2'b00, 0, 1,  1, 0, 8'd4, 1, 0, 0);
        add(0, 2'b00, 0, 1,  0, 0, 8'd0, 0, 0, 0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].spk, vq[i].tck, vq[i].rdy);
            step();
            check_head($sformatf("vec%0d", i), vq[i].vld, vq[i].chan, vq[i].ts, vq[i].lvl);
            chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vq[i].ovf));
            chk($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'(vq[i].drop));
        end

        // Backpressure: six spikes on alternating channels, spike k carries ts = k.
        drive(1, 2'b00, 0, 0); step();
        for (int k = 0; k < 6; k++) begin
            drive(0, (k % 2 == 1) ? 2'b10 : 2'b01, 0, 0);
            step();
            if (k > 0) check_head($sformatf("stall spike%0d", k), 1, 0, 8'd0, (k < 4) ? 3'(k) : 3'd4);
            drive(0, 2'b00, 1, 0);
            step();
            check_head($sformatf("stall idle%0d", k), 1, 0, 8'd0, (k < 4) ? 3'(k + 1) : 3'd4);
        end
        begin
            int got = 0;
            int cyc = 0;
            drive(0, 2'b00, 0, 1);
            while (got < 6 && cyc < 30) begin
                if (ev_if.ev_valid) begin
                    got_chan[got] = ev_if.ev_chan;
                    got_ts[got]   = ev_if.ev_ts;
                    got++;
                end
                step();
                cyc++;
            end
            chk("drain count", 32'(got), 32'd6);
            for (int k = 0; k < 6; k++) begin
                exp_chan[k] = (k % 2 == 1);
                exp_ts[k]   = 8'(k);
                if (k < got) begin
                    chk($sformatf("drain%0d chan", k), 32'(got_chan[k]), 32'(exp_chan[k]));
                    chk($sformatf("drain%0d ts", k),   32'(got_ts[k]),   32'(exp_ts[k]));
                end
            end
            step();
            chk("drain level", 32'(fifo_level), 32'd0);
            chk("drain drop_cnt", 32'(drop_cnt), 32'd0);
            chk("drain overflow", 32'(overflow), 32'd0);
        end

        // Drop and saturation: channel 0 held high with no consumer.
        drive(1, 2'b00, 0, 0); step();
        drive(0, 2'b01, 0, 0);
        for (int i = 0; i < 7; i++) step();
        chk("drop early cnt", 32'(drop_cnt), 32'd2);
        chk("drop early ovf", 32'(overflow), 32'd1);
        chk("drop level", 32'(fifo_level), 32'd4);
        for (int i = 7; i < 259; i++) step();
        chk("drop 254", 32'(drop_cnt), 32'd254);
        for (int i = 259; i < 300; i++) step();
        chk("drop saturated", 32'(drop_cnt), 32'd255);
        chk("drop ovf sticky", 32'(overflow), 32'd1);

        // Timestamp wrap: 255 ticks, spike with the 256th tick sees 255, the next spike sees 0.
        drive(1, 2'b00, 0, 1); step();
        chk("reset clears ovf", 32'(overflow), 32'd0);
        chk("reset clears drop", 32'(drop_cnt), 32'd0);
        drive(0, 2'b00, 1, 1);
        for (int i = 0; i < 255; i++) step();
        drive(0, 2'b01, 1, 1); step();
        check_head("wrap spike", 0, 0, 8'd0, 0);
        drive(0, 2'b00, 0, 1); step();
        check_head("wrap ts255", 1, 0, 8'd255, 1);
        drive(0, 2'b10, 0, 1); step();
        check_head("wrap pop", 0, 0, 8'd0, 0);
        drive(0, 2'b00, 0, 1); step();
        check_head("wrap ts0", 1, 1, 8'd0, 1);
        step();
        check_head("wrap empty", 0, 0, 8'd0, 0);

        // Reset mid-stream with three queued events and one pending.
        drive(0, 2'b00, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, (k == 1) ? 2'b10 : 2'b01, 0, 0); step();
            drive(0, 2'b00, 0, 0); step();
        end
        chk("mid level3", 32'(fifo_level), 32'd3);
        drive(0, 2'b10, 0, 0); step();
        drive(1, 2'b00, 0, 0); step();
        check_head("mid reset", 0, 0, 8'd0, 0);
        begin
            int stale = 0;
            drive(0, 2'b00, 0, 1);
            for (int i = 0; i < 10; i++) begin
                step();
                if (ev_if.ev_valid !== 1'b0 || fifo_level !== 3'd0) stale++;
            end
            chk("no stale events", 32'(stale), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Receiving end of the neuron spike interface. Captures one-cycle spike pulses from N_CH neuron outputs and stamps each with the current timestep count.
- Queues the stamped events in a small FIFO and presents them one at a time on a valid/ready event port.
- Sits between the dual ALIF neuron core and the readout/serialiser logic.
- Counts events lost to contention.

Parameters:
- N_CH, 2, number of spike input channels (>=2).
- CH_W, 1, channel index width; must equal clog2(N_CH).
- TS_W, 8, timestamp width.
- DEPTH, 4, FIFO depth; power of two, >=2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- spike_in  input  N_CH  per-channel spike pulse; each high cycle is one spike.
- tick  input  1  timestep strobe; advances the timestamp counter.
- ev_valid  output  1  event available at the head of the FIFO.
- ev_ready  input  1  consumer accepts the event.
- ev_chan  output  CH_W  channel index of the head event.
- ev_ts  output  TS_W  timestamp of the head event.
- fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: at least one spike was dropped.
- drop_cnt  output  8  number of dropped spikes, saturating at 255.

Behaviour:
- Reset: one clock, synchronous, active-high. rst high at a rising edge clears all state:
  - ts counter = 0, pending = 0, FIFO empty.
  - ev_valid = 0, ev_chan = 0, ev_ts = 0, fifo_level = 0, overflow = 0, drop_cnt = 0.
  - Reset mid-operation discards all queued and pending events; no partial event is emitted.
- Timestamp counter:
  - Increments by 1 on each edge where tick = 1; wraps modulo 2^TS_W (255 -> 0).
  - A spike sampled in the same cycle as tick takes the pre-increment value.
- Pending stage: one pending bit plus one latched TS_W timestamp per channel.
  - At each edge with spike_in[i] = 1:
    - pending[i] = 0: set pending[i] and latch the ts counter.
    - pending[i] = 1 and not drained this edge: the spike is dropped. Set overflow; increment drop_cnt unless it is 255.
    - pending[i] = 1 and drained this edge: no drop. pending[i] stays set with the new timestamp.
  - Several channels spiking in one cycle each occupy their own pending slot; no drop.
- Drain / arbitration:
  - At most one push per edge.
  - Picks the lowest-index set pending bit (fixed priority, channel 0 highest).
  - Writes {index, latched ts} to the FIFO and clears that pending bit.
  - Push is allowed when the FIFO is not full, or when it is full and a pop occurs in the same edge.
  - When the FIFO is full with no pop, pending bits hold; later spikes on a held channel are dropped.
- FIFO and handshake:
  - Circular buffer with DEPTH entries, read/write pointers, and an occupancy counter.
  - ev_valid = (fifo_level != 0). ev_chan and ev_ts are driven combinationally from the head entry.
  - Pop occurs on an edge with ev_valid && ev_ready.
  - While ev_valid = 1 and ev_ready = 0, ev_chan and ev_ts hold stable.
  - ev_ready while empty has no effect.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo DEPTH.
- Latency:
  - Spike at cycle t with the FIFO empty and no contention: pending set at edge t, pushed at edge t+1.
  - ev_valid is high in cycle t+2 (two-cycle latency).
- Order:
  - Events from one channel leave in arrival order.
  - Across channels, order follows arbitration order.
- Width rules:
  - Timestamps are unsigned and wrap; no sign handling.
  - drop_cnt saturates and never wraps.
  - overflow clears only on rst.

Test Plan:
- Reset / idle: rst for 2 cycles, then idle 10 cycles -> ev_valid = 0, fifo_level = 0, overflow = 0, drop_cnt = 0, ev_ts = 0.
- Single spike with timestamp:
  - Stimulus: 5 tick pulses, then spike_in = 01 in one cycle, ev_ready = 1.
  - Expected: ev_valid high exactly 2 cycles later for 1 cycle, ev_chan = 0, ev_ts = 5.
- Simultaneous channels:
  - Stimulus: spike_in = 11 in one cycle, at the same cycle as a tick with ts = 3.
  - Expected: two events in order (chan 0, ts 3) then (chan 1, ts 3); ts counter then reads 4.
- Backpressure and full:
  - Stimulus: ev_ready = 0; six spikes on alternating channels, 1 idle cycle between each.
  - Expected:
    - fifo_level saturates at 4; the 5th and 6th spikes sit in pending.
    - ev_chan and ev_ts stay stable while stalled.
    - Releasing ev_ready drains all 6 events in order; drop_cnt = 0.
- Drop and saturation:
  - Stimulus: ev_ready = 0, then spike_in[0] held high for 300 cycles.
  - Expected: overflow = 1; drop_cnt = 255, saturated and not wrapped.
- Wrap and reset mid-stream:
  - Stimulus: 256 ticks, then a spike.
  - Expected: ev_ts = 0.
  - Stimulus: fill 3 entries, then assert rst for 1 cycle.
  - Expected: ev_valid = 0 and fifo_level = 0 in the next cycle; no stale events appear afterwards.
